// File: rtl/lvds_rx_iq_pkg.sv
// Shared state encodings, default sync codes and frame-width helper for the lvds_rx_iq receiver.
package lvds_rx_iq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_I_PHASE = 2'b01,
      ST_Q_PHASE = 2'b11
   } rx_state_e;

   localparam logic [1:0] DEF_I_SYNC      = 2'b10;
   localparam logic [1:0] DEF_Q_SYNC      = 2'b01;
   localparam int         DEF_DATA_DIBITS = 7;

   // Frame word width: two phases, each one sync dibit plus the data dibits.
   function automatic int word_width(input int data_dibits);
      return 4 * (data_dibits + 1);
   endfunction

endpackage

// File: rtl/lvds_rx_sat_cnt.sv
// Saturating status counter with synchronous clear; clear wins over a simultaneous increment.
module lvds_rx_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count events, holding at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= {CNT_W{1'b0}};
      end else if (clear) begin
         count <= {CNT_W{1'b0}};
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/lvds_rx_iq.sv
// lvds_rx_iq: deserialises the DDR dibit stream into {I,Q} frame words, checks both syncs, gates pushes on lock.
// Define LVDS_RX_STATUS_CNT_EN to build the overflow and sync-error counters; otherwise both read 0.
module lvds_rx_iq
   import lvds_rx_iq_pkg::*;
#(
   parameter int         DATA_DIBITS = DEF_DATA_DIBITS,
   parameter logic [1:0] I_SYNC      = DEF_I_SYNC,
   parameter logic [1:0] Q_SYNC      = DEF_Q_SYNC,
   parameter int         LOCK_FRAMES = 2,
   parameter int         CNT_W       = 16,
   localparam int        W           = word_width(DATA_DIBITS)
) (
   input  logic             i_ddr_clk,
   input  logic             i_reset_n,
   input  logic [1:0]       i_ddr_data,
   input  logic             i_enable,
   input  logic             i_cnt_clear,
   input  logic             i_fifo_full,
   output logic             o_fifo_write_clk,
   output logic             o_fifo_push,
   output logic [W-1:0]     o_fifo_data,
   output logic             o_locked,
   output logic [CNT_W-1:0] o_overflow_cnt,
   output logic [CNT_W-1:0] o_sync_err_cnt,
   output logic [1:0]       o_debug_state
);

   localparam int            CW         = $clog2(DATA_DIBITS + 1);
   localparam int            LW         = $clog2(LOCK_FRAMES + 2);
   localparam int            SW         = W - 2;
   localparam logic [CW-1:0] CNT_RELOAD = CW'(DATA_DIBITS - 1);
   localparam logic [CW-1:0] CNT_IDLE   = CW'(DATA_DIBITS);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [LW-1:0] LOCK_THR   = LW'(LOCK_FRAMES);

   rx_state_e         state_r;
   logic [CW-1:0]     cnt_r;
   logic              qsync_due_r;
   logic [SW-1:0]     shift_r;
   logic [LW-1:0]     lock_r;
   logic              locked_s;
   logic              lock_at_thr_s;
   logic              sync_err_evt_s;
   logic              ovf_evt_s;

   assign locked_s         = (lock_r == LOCK_THR);
   assign lock_at_thr_s    = (lock_r >= LOCK_THR);
   assign o_locked         = locked_s;
   assign o_fifo_write_clk = i_ddr_clk;
   assign o_debug_state    = state_r;

   // Per-dibit sync-error and overflow events, shared by the FSM and the status counters.
   always_comb begin
      sync_err_evt_s = 1'b0;
      ovf_evt_s      = 1'b0;
      if (i_enable) begin
         case (state_r)
            ST_IDLE:    sync_err_evt_s = (i_ddr_data != I_SYNC) && locked_s;
            ST_I_PHASE: sync_err_evt_s = qsync_due_r && (i_ddr_data != Q_SYNC);
            ST_Q_PHASE: ovf_evt_s      = (cnt_r == CNT_ZERO) && lock_at_thr_s && i_fifo_full;
            default: begin
               sync_err_evt_s = 1'b0;
               ovf_evt_s      = 1'b0;
            end
         endcase
      end else begin
         sync_err_evt_s = 1'b0;
         ovf_evt_s      = 1'b0;
      end
   end

   // Frame FSM: sync hunt, I phase, Q phase; qsync_due_r marks the dibit after the last I data dibit.
   always_ff @(posedge i_ddr_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_IDLE;
         qsync_due_r <= 1'b0;
         shift_r     <= {SW{1'b0}};
         lock_r      <= {LW{1'b0}};
         o_fifo_push <= 1'b0;
         o_fifo_data <= {W{1'b0}};
      end else if (!i_enable) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_IDLE;
         qsync_due_r <= 1'b0;
         lock_r      <= {LW{1'b0}};
         o_fifo_push <= 1'b0;
      end else begin
         o_fifo_push <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (i_ddr_data == I_SYNC) begin
                  shift_r     <= {{(SW-2){1'b0}}, I_SYNC};
                  cnt_r       <= CNT_RELOAD;
                  qsync_due_r <= 1'b0;
                  state_r     <= ST_I_PHASE;
               end else if (sync_err_evt_s) begin
                  lock_r <= {LW{1'b0}};
               end else begin
                  lock_r <= lock_r;
               end
            end
            ST_I_PHASE: begin
               if (qsync_due_r) begin
                  qsync_due_r <= 1'b0;
                  if (i_ddr_data == Q_SYNC) begin
                     shift_r <= {shift_r[SW-3:0], i_ddr_data};
                     cnt_r   <= CNT_RELOAD;
                     state_r <= ST_Q_PHASE;
                  end else begin
                     lock_r  <= {LW{1'b0}};
                     cnt_r   <= CNT_IDLE;
                     state_r <= ST_IDLE;
                  end
               end else begin
                  shift_r <= {shift_r[SW-3:0], i_ddr_data};
                  if (cnt_r == CNT_ZERO) begin
                     qsync_due_r <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r - CW'(1);
                  end
               end
            end
            ST_Q_PHASE: begin
               shift_r <= {shift_r[SW-3:0], i_ddr_data};
               if (cnt_r == CNT_ZERO) begin
                  o_fifo_data <= {shift_r, i_ddr_data};
                  if (lock_at_thr_s) begin
                     o_fifo_push <= !ovf_evt_s;
                  end else begin
                     lock_r <= lock_r + LW'(1);
                  end
                  cnt_r   <= CNT_IDLE;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            default: begin
               cnt_r       <= CNT_IDLE;
               qsync_due_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef LVDS_RX_STATUS_CNT_EN
   lvds_rx_sat_cnt #(.CNT_W(CNT_W)) u_ovf_cnt (
      .clk     (i_ddr_clk),
      .reset_n (i_reset_n),
      .clear   (i_cnt_clear),
      .inc     (ovf_evt_s),
      .count   (o_overflow_cnt)
   );

   lvds_rx_sat_cnt #(.CNT_W(CNT_W)) u_sync_err_cnt (
      .clk     (i_ddr_clk),
      .reset_n (i_reset_n),
      .clear   (i_cnt_clear),
      .inc     (sync_err_evt_s),
      .count   (o_sync_err_cnt)
   );
`else
   logic unused_cnt_clear_s;
   assign unused_cnt_clear_s = i_cnt_clear;
   assign o_overflow_cnt     = {CNT_W{1'b0}};
   assign o_sync_err_cnt     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lvds_rx_iq.sv
// Bench for lvds_rx_iq: frame table, directed corner sequences and random stream against a dibit-queue model.
module tb_lvds_rx_iq;

   localparam int         DD   = 7;
   localparam int         W    = 4 * (DD + 1);
   localparam int         NDIB = 2 * (DD + 1);
   localparam int         LF   = 2;
   localparam int         CW   = 4;
   localparam logic [1:0] IS   = 2'b10;
   localparam logic [1:0] QS   = 2'b01;
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};
   localparam logic [W-1:0]  GOOD = 32'h8123_4567;
   localparam logic [W-1:0]  BADQ = 32'h8123_C555;
`ifdef LVDS_RX_STATUS_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    dib   = 2'b00;
   logic          en    = 1'b0;
   logic          clr   = 1'b0;
   logic          full  = 1'b0;
   logic          wclk;
   logic          push;
   logic [W-1:0]  data;
   logic          locked;
   logic [CW-1:0] ovf_cnt;
   logic [CW-1:0] serr_cnt;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   lvds_rx_iq #(
      .DATA_DIBITS (DD),
      .I_SYNC      (IS),
      .Q_SYNC      (QS),
      .LOCK_FRAMES (LF),
      .CNT_W       (CW)
   ) dut (
      .i_ddr_clk        (clk),
      .i_reset_n        (rst_n),
      .i_ddr_data       (dib),
      .i_enable         (en),
      .i_cnt_clear      (clr),
      .i_fifo_full      (full),
      .o_fifo_write_clk (wclk),
      .o_fifo_push      (push),
      .o_fifo_data      (data),
      .o_locked         (locked),
      .o_overflow_cnt   (ovf_cnt),
      .o_sync_err_cnt   (serr_cnt),
      .o_debug_state    (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int pushes   = 0;

   // Reference model: dibits collected since the accepted I sync, plus frame-level lock and counters.
   logic [1:0]    mq[$];
   int            m_lock;
   logic          m_push;
   logic [W-1:0]  m_data;
   logic [CW-1:0] m_serr;
   logic [CW-1:0] m_ovf;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] cnt_exp(input logic [CW-1:0] v);
      return CNT_EN ? v : {CW{1'b0}};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_lock = 0;
      m_push = 1'b0;
      m_data = '0;
      m_serr = '0;
      m_ovf  = '0;
   endtask

   task automatic model_step(input logic [1:0] d, input logic e, input logic f, input logic c);
      bit serr_ev = 1'b0;
      bit ovf_ev  = 1'b0;
      logic [W-1:0] word;
      m_push = 1'b0;
      if (!e) begin
         mq.delete();
         m_lock = 0;
      end else if (mq.size() == 0) begin
         if (d == IS) mq.push_back(d);
         else if (m_lock == LF) begin
            serr_ev = 1'b1;
            m_lock  = 0;
         end
      end else if (mq.size() == DD + 1 && d != QS) begin
         serr_ev = 1'b1;
         m_lock  = 0;
         mq.delete();
      end else begin
         mq.push_back(d);
         if (mq.size() == NDIB) begin
            word = '0;
            foreach (mq[i]) word = {word[W-3:0], mq[i]};
            m_data = word;
            if (m_lock >= LF) begin
               if (f) ovf_ev = 1'b1;
               else   m_push = 1'b1;
            end else begin
               m_lock++;
            end
            mq.delete();
         end
      end
      if (c) m_serr = '0;
      else if (serr_ev && m_serr != CMAX) m_serr++;
      if (c) m_ovf = '0;
      else if (ovf_ev && m_ovf != CMAX) m_ovf++;
   endtask

   task automatic step(input logic [1:0] d, input logic e, input logic f, input logic c);
      dib  = d;
      en   = e;
      full = f;
      clr  = c;
      model_step(d, e, f, c);
      @(posedge clk);
      #1;
      if (push) pushes++;
      check("cyc_push", push, m_push);
      check("cyc_data", data, m_data);
      check("cyc_locked", locked, (m_lock == LF));
      check("cyc_ovf", ovf_cnt, cnt_exp(m_ovf));
      check("cyc_serr", serr_cnt, cnt_exp(m_serr));
   endtask

   task automatic send_frame(input logic [W-1:0] word, input logic f, input logic clr_last);
      pushes = 0;
      for (int i = 0; i < NDIB; i++)
         step(word[W-1-2*i -: 2], 1'b1, f, clr_last && (i == NDIB - 1));
   endtask

   function automatic logic [W-1:0] rand_frame(input logic [1:0] qsync);
      logic [13:0] a;
      logic [13:0] b;
      a = 14'($urandom);
      b = 14'($urandom);
      return {IS, a, qsync, b};
   endfunction

   typedef struct {
      logic [W-1:0]  word;
      logic          full;
      int            exp_pushes;
      logic          exp_locked;
      logic [CW-1:0] exp_ovf;
      logic [CW-1:0] exp_serr;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{GOOD, 1'b0, 0, 1'b0, 4'd0, 4'd0};
      vecs[1]  = '{GOOD, 1'b0, 0, 1'b1, 4'd0, 4'd0};
      vecs[2]  = '{GOOD, 1'b0, 1, 1'b1, 4'd0, 4'd0};
      vecs[3]  = '{BADQ, 1'b0, 0, 1'b0, 4'd0, 4'd1};
      vecs[4]  = '{GOOD, 1'b0, 0, 1'b0, 4'd0, 4'd1};
      vecs[5]  = '{GOOD, 1'b0, 0, 1'b1, 4'd0, 4'd1};
      vecs[6]  = '{GOOD, 1'b0, 1, 1'b1, 4'd0, 4'd1};
      vecs[7]  = '{GOOD, 1'b1, 0, 1'b1, 4'd1, 4'd1};
      vecs[8]  = '{GOOD, 1'b1, 0, 1'b1, 4'd2, 4'd1};
      vecs[9]  = '{GOOD, 1'b1, 0, 1'b1, 4'd3, 4'd1};
      vecs[10] = '{GOOD, 1'b0, 1, 1'b1, 4'd3, 4'd1};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_push", push, 1'b0);
      check("rst_data", data, '0);
      check("rst_locked", locked, 1'b0);
      check("rst_ovf", ovf_cnt, '0);
      check("rst_serr", serr_cnt, '0);
      check("rst_state", dbg_state, 2'b00);
      check("write_clk", wclk, clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Lock acquisition, Q sync error recovery, FIFO full.
      for (int v = 0; v < 11; v++) begin
         send_frame(vecs[v].word, vecs[v].full, 1'b0);
         check($sformatf("tbl%0d_pushes", v), pushes, vecs[v].exp_pushes);
         check($sformatf("tbl%0d_locked", v), locked, vecs[v].exp_locked);
         check($sformatf("tbl%0d_data", v), data, GOOD);
         check($sformatf("tbl%0d_ovf", v), ovf_cnt, cnt_exp(vecs[v].exp_ovf));
         check($sformatf("tbl%0d_serr", v), serr_cnt, cnt_exp(vecs[v].exp_serr));
      end

      // Missing I sync while locked, then idle hunting while unlocked.
      step(2'b00, 1'b1, 1'b0, 1'b0);
      check("miss_isync_locked", locked, 1'b0);
      check("miss_isync_serr", serr_cnt, cnt_exp(4'd2));
      repeat (20) step(2'b00, 1'b1, 1'b0, 1'b0);
      check("idle_hunt_serr", serr_cnt, cnt_exp(4'd2));

      // Overflow saturation and clear coincident with an overflow.
      repeat (3) send_frame(GOOD, 1'b0, 1'b0);
      check("relock_push", pushes, 1);
      repeat (20) send_frame(GOOD, 1'b1, 1'b0);
      check("ovf_saturate", ovf_cnt, cnt_exp(4'd15));
      send_frame(GOOD, 1'b1, 1'b1);
      check("ovf_clear_wins", ovf_cnt, '0);
      check("serr_cleared", serr_cnt, '0);

      // Enable dropped at dibit 5 of a locked frame.
      for (int i = 0; i < 5; i++) step(GOOD[W-1-2*i -: 2], 1'b1, 1'b0, 1'b0);
      step(GOOD[W-1-10 -: 2], 1'b0, 1'b0, 1'b0);
      check("en_low_state", dbg_state, 2'b00);
      check("en_low_locked", locked, 1'b0);
      check("en_low_push", push, 1'b0);
      for (int i = 6; i < NDIB; i++) step(GOOD[W-1-2*i -: 2], 1'b1, 1'b0, 1'b0);
      repeat (16) step(2'b00, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of the Q phase.
      repeat (3) send_frame(GOOD, 1'b0, 1'b0);
      check("pre_rst_push", pushes, 1);
      for (int i = 0; i < 11; i++) step(GOOD[W-1-2*i -: 2], 1'b1, 1'b0, 1'b0);
      check("pre_rst_state", dbg_state, 2'b11);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_push", push, 1'b0);
      check("async_rst_data", data, '0);
      check("async_rst_locked", locked, 1'b0);
      check("async_rst_ovf", ovf_cnt, '0);
      check("async_rst_serr", serr_cnt, '0);
      check("async_rst_state", dbg_state, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Random stream of good, corrupted and garbage frames with idles, full, clear and enable drops.
      for (int s = 0; s < 80; s++) begin
         int           kind;
         logic         f;
         logic [W-1:0] w;
         int           drop_at;
         kind    = $urandom_range(0, 9);
         f       = ($urandom_range(0, 3) == 0);
         drop_at = -1;
         if (kind <= 5)      w = rand_frame(QS);
         else if (kind == 6) w = rand_frame(QS ^ 2'($urandom_range(1, 3)));
         else if (kind == 7) w = W'($urandom);
         else if (kind == 9) begin
            w       = rand_frame(QS);
            drop_at = $urandom_range(0, NDIB - 1);
         end else w = '0;
         if (kind == 8) begin
            repeat ($urandom_range(1, 5)) step(2'($urandom), 1'b1, f, ($urandom_range(0, 19) == 0));
         end else begin
            for (int i = 0; i < NDIB; i++)
               step(w[W-1-2*i -: 2], (i != drop_at), f, (i != drop_at) && ($urandom_range(0, 19) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
